// File: rtl/core_input_buf_pkg.sv
// Shared constants, FSM state type and slot-index helper for the core-input buffer.
package core_input_buf_pkg;

  localparam int BLK_OP_MSB = 2;
  localparam int N_WORDS    = 16;
  localparam int WORD_W     = 32;
  localparam int RAM_AW     = 6;

  localparam logic [3:0] LAST_WORD = 4'(N_WORDS - 1);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } rd_state_e;

  // Slots are numbered {ctx,seq}; this ordering is also the RAM address MSBs.
  function automatic logic [1:0] slot_idx(input logic ctx, input logic seq);
    return {ctx, seq};
  endfunction

endpackage

// File: rtl/core_input_ram.sv
// 64x32 block store: one synchronous write port, one registered read port (distributed RAM).
module core_input_ram
  import core_input_buf_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [RAM_AW-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [RAM_AW-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [2**RAM_AW];
  logic [WORD_W-1:0] r_rdata;

  // Storage is deliberately not reset so it maps onto LUT RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/core_input_buf.sv
// Core-side receiver: captures engine blocks into four {ctx,seq} slots and streams them to the SHA-256 core.
// Optional CORE_INPUT_WCNT_EN adds a per-slot written-word mask flagging incomplete or duplicated blocks.
module core_input_buf
  import core_input_buf_pkg::*;
#(
  parameter int BLK_OP_W = BLK_OP_MSB + 1
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                wr_en,
  input  logic [31:0]         din,
  input  logic [3:0]          wr_addr,
  input  logic [BLK_OP_W-1:0] blk_op,
  input  logic                input_ctx,
  input  logic                input_seq,
  input  logic                set_input_ready,
  output logic [3:0]          ready,
  output logic [1:0]          blk_avail,
  input  logic                rd_start,
  input  logic                rd_ctx,
  output logic                busy,
  output logic [31:0]         dout,
  output logic                dout_valid,
  output logic [3:0]          dout_addr,
  output logic [BLK_OP_W-1:0] dout_blk_op,
  output logic                dout_ctx,
  output logic                dout_last,
  output logic                err
);

  logic [3:0]          r_full;
  logic [BLK_OP_W-1:0] r_slot_op [4];
  logic [1:0]          r_rd_seq;
  rd_state_e           r_state;
  rd_state_e           w_next_state;
  logic                r_ctx;
  logic                r_seq;
  logic                r_issue_done;
  logic [3:0]          r_cnt;
  logic [BLK_OP_W-1:0] r_cur_op;
  logic                r_dout_valid;
  logic                r_dout_last;
  logic [3:0]          r_dout_addr;
  logic                r_err;

  logic [1:0]          w_wr_slot;
  logic [1:0]          w_rd_slot;
  logic [1:0]          w_cur_slot;
  logic                w_wr_ok;
  logic                w_wr_err;
  logic                w_set_ok;
  logic                w_set_err;
  logic                w_accept;
  logic                w_rd_err;
  logic                w_issue;
  logic                w_done;
  logic                w_mask_err;
  logic [3:0]          w_set_mask;
  logic [3:0]          w_clr_mask;
  logic [WORD_W-1:0]   w_ram_rdata;

  assign w_wr_slot  = slot_idx(input_ctx, input_seq);
  assign w_rd_slot  = slot_idx(rd_ctx, r_rd_seq[rd_ctx]);
  assign w_cur_slot = slot_idx(r_ctx, r_seq);

  assign w_wr_ok   = wr_en & ~r_full[w_wr_slot];
  assign w_wr_err  = wr_en & r_full[w_wr_slot];
  assign w_set_ok  = set_input_ready & ~r_full[w_wr_slot];
  assign w_set_err = set_input_ready & r_full[w_wr_slot];

  assign w_set_mask = w_set_ok ? (4'b0001 << w_wr_slot) : 4'b0000;
  assign w_clr_mask = w_done ? (4'b0001 << w_cur_slot) : 4'b0000;

  assign ready     = ~r_full;
  assign blk_avail = {r_full[slot_idx(1'b1, r_rd_seq[1])], r_full[slot_idx(1'b0, r_rd_seq[0])]};

  // Reads issue for 16 cycles, then the FSM lingers one more cycle so the
  // slot is released on the cycle word 15 is actually on dout.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_rd_err     = 1'b0;
    w_issue      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rd_start) begin
          if (blk_avail[rd_ctx]) begin
            w_accept     = 1'b1;
            w_next_state = S_STREAM;
          end else begin
            w_rd_err = 1'b1;
          end
        end
      end
      S_STREAM: begin
        w_issue = ~r_issue_done;
        if (r_dout_valid && r_dout_last) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

`ifdef CORE_INPUT_WCNT_EN
  logic [N_WORDS-1:0] r_mask [4];
  logic [N_WORDS-1:0] w_wr_bit;

  // The coincident word-15 write counts towards completeness of the set.
  always_comb begin
    w_wr_bit          = '0;
    w_wr_bit[wr_addr] = w_wr_ok;
    w_mask_err        = (w_wr_ok && ((r_mask[w_wr_slot] & w_wr_bit) != '0)) ||
                        (w_set_ok && ((r_mask[w_wr_slot] | w_wr_bit) != '1));
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 4; i++) begin
        r_mask[i] <= '0;
      end
    end else if (w_set_ok) begin
      r_mask[w_wr_slot] <= '0;
    end else if (w_wr_ok) begin
      r_mask[w_wr_slot] <= r_mask[w_wr_slot] | w_wr_bit;
    end
  end
`else
  assign w_mask_err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_full   <= 4'b0000;
      r_rd_seq <= 2'b00;
      r_err    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_slot_op[i] <= '0;
      end
    end else begin
      r_full <= (r_full | w_set_mask) & ~w_clr_mask;
      r_err  <= r_err | w_wr_err | w_set_err | w_rd_err | w_mask_err;
      if (w_set_ok) begin
        r_slot_op[w_wr_slot] <= blk_op;
      end
      if (w_done) begin
        r_rd_seq[r_ctx] <= ~r_rd_seq[r_ctx];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ctx        <= 1'b0;
      r_seq        <= 1'b0;
      r_cur_op     <= '0;
      r_cnt        <= 4'd0;
      r_issue_done <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
      r_dout_addr  <= 4'd0;
    end else begin
      if (w_accept) begin
        r_ctx        <= rd_ctx;
        r_seq        <= r_rd_seq[rd_ctx];
        r_cur_op     <= r_slot_op[w_rd_slot];
        r_cnt        <= 4'd0;
        r_issue_done <= 1'b0;
      end else if (w_issue) begin
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt == LAST_WORD) begin
          r_issue_done <= 1'b1;
        end
      end
      r_dout_valid <= w_issue;
      r_dout_last  <= w_issue && (r_cnt == LAST_WORD);
      if (w_issue) begin
        r_dout_addr <= r_cnt;
      end
    end
  end

  core_input_ram u_ram (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_we    (w_wr_ok),
    .i_waddr ({w_wr_slot, wr_addr}),
    .i_wdata (din),
    .i_re    (w_issue),
    .i_raddr ({w_cur_slot, r_cnt}),
    .o_rdata (w_ram_rdata)
  );

  assign busy        = (r_state == S_STREAM);
  assign dout        = w_ram_rdata;
  assign dout_valid  = r_dout_valid;
  assign dout_addr   = r_dout_addr;
  assign dout_blk_op = r_cur_op;
  assign dout_ctx    = r_ctx;
  assign dout_last   = r_dout_last;
  assign err         = r_err;

endmodule

// File: tb/tb_core_input_buf.sv
// Scoreboard bench for core_input_buf: a slot/RAM model predicts every streamed word and flag.
// Build with CORE_INPUT_WCNT_EN defined to expect the incomplete-block error.
module tb_core_input_buf;
  import core_input_buf_pkg::*;

  localparam int BLK_OP_W = BLK_OP_MSB + 1;
`ifdef CORE_INPUT_WCNT_EN
  localparam logic WCNT = 1'b1;
`else
  localparam logic WCNT = 1'b0;
`endif

  logic                CLK;
  logic                RESET_N;
  logic                wr_en;
  logic [31:0]         din;
  logic [3:0]          wr_addr;
  logic [BLK_OP_W-1:0] blk_op;
  logic                input_ctx;
  logic                input_seq;
  logic                set_input_ready;
  logic [3:0]          ready;
  logic [1:0]          blk_avail;
  logic                rd_start;
  logic                rd_ctx;
  logic                busy;
  logic [31:0]         dout;
  logic                dout_valid;
  logic [3:0]          dout_addr;
  logic [BLK_OP_W-1:0] dout_blk_op;
  logic                dout_ctx;
  logic                dout_last;
  logic                err;

  core_input_buf dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .wr_en           (wr_en),
    .din             (din),
    .wr_addr         (wr_addr),
    .blk_op          (blk_op),
    .input_ctx       (input_ctx),
    .input_seq       (input_seq),
    .set_input_ready (set_input_ready),
    .ready           (ready),
    .blk_avail       (blk_avail),
    .rd_start        (rd_start),
    .rd_ctx          (rd_ctx),
    .busy            (busy),
    .dout            (dout),
    .dout_valid      (dout_valid),
    .dout_addr       (dout_addr),
    .dout_blk_op     (dout_blk_op),
    .dout_ctx        (dout_ctx),
    .dout_last       (dout_last),
    .err             (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0]         data;
    logic [3:0]          addr;
    logic                last;
    logic [BLK_OP_W-1:0] op;
    logic                ctx;
    logic                seq;
  } expWord_t;

  expWord_t            expQ[$];
  expWord_t            monE;
  logic                expectNext;
  logic [31:0]         memModel [64];
  logic [3:0]          fullModel;
  logic [BLK_OP_W-1:0] opModel [4];
  logic [1:0]          rdSeqModel;
  logic                errModel;
  int                  nChecks;
  int                  nFail;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void modelReset();
    fullModel  = 4'b0000;
    rdSeqModel = 2'b00;
    errModel   = 1'b0;
    expQ.delete();
  endfunction

  function automatic void modelWrite(input logic ctx, input logic seq, input logic [3:0] addr,
                                     input logic [31:0] data);
    if (fullModel[{ctx, seq}]) errModel = 1'b1;
    else memModel[{ctx, seq, addr}] = data;
  endfunction

  function automatic void modelSet(input logic ctx, input logic seq, input logic [BLK_OP_W-1:0] op);
    if (fullModel[{ctx, seq}]) begin
      errModel = 1'b1;
    end else begin
      fullModel[{ctx, seq}] = 1'b1;
      opModel[{ctx, seq}]   = op;
    end
  endfunction

  function automatic logic modelRead(input logic ctx);
    expWord_t e;
    logic     seq;
    seq = rdSeqModel[ctx];
    if (!fullModel[{ctx, seq}]) begin
      errModel = 1'b1;
      return 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      e.data = memModel[{ctx, seq, 4'(i)}];
      e.addr = 4'(i);
      e.last = (i == 15);
      e.op   = opModel[{ctx, seq}];
      e.ctx  = ctx;
      e.seq  = seq;
      expQ.push_back(e);
    end
    return 1'b1;
  endfunction

  // Drives one cycle of engine-side inputs and mirrors it into the model.
  task automatic applyStimulus(input logic we, input logic ctx, input logic seq, input logic [3:0] addr,
                               input logic [31:0] data, input logic set, input logic [BLK_OP_W-1:0] op);
    @(negedge CLK);
    wr_en           = we;
    input_ctx       = ctx;
    input_seq       = seq;
    wr_addr         = addr;
    din             = data;
    set_input_ready = set;
    blk_op          = op;
    if (we) modelWrite(ctx, seq, addr, data);
    if (set) modelSet(ctx, seq, op);
  endtask

  task automatic idleInputs();
    @(negedge CLK);
    wr_en           = 1'b0;
    set_input_ready = 1'b0;
  endtask

  task automatic writeBlock(input logic ctx, input logic seq, input logic [31:0] base,
                            input logic [BLK_OP_W-1:0] op);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, ctx, seq, 4'(i), base + 32'(i), i == 15, op);
    end
    idleInputs();
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, "_ready"}, {28'd0, ready}, {28'd0, ~fullModel});
    checkOutput({tag, "_avail"}, {30'd0, blk_avail},
                {30'd0, fullModel[{1'b1, rdSeqModel[1]}], fullModel[{1'b0, rdSeqModel[0]}]});
    checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, errModel});
  endtask

  task automatic startRead(input logic ctx);
    logic acc;
    @(negedge CLK);
    rd_start = 1'b1;
    rd_ctx   = ctx;
    acc      = modelRead(ctx);
    @(negedge CLK);
    rd_start = 1'b0;
    checkOutput("busy_after_start", {31'd0, busy}, {31'd0, acc});
    checkOutput("valid_lat1", {31'd0, dout_valid}, 32'd0);
    @(negedge CLK);
    checkOutput("valid_lat2", {31'd0, dout_valid}, {31'd0, acc});
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((busy || expQ.size() != 0) && n < 40) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("burst_done", {31'd0, (busy || expQ.size() != 0)}, 32'd0);
  endtask

  task automatic applyReset();
    @(negedge CLK);
    RESET_N = 1'b0;
    modelReset();
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  // Scoreboard consumer: every valid word must match the head of the queue,
  // and a burst must not pause between its first and last word.
  always @(negedge CLK) begin
    if (!RESET_N) begin
      expectNext = 1'b0;
    end else if (dout_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_valid", {31'd0, dout_valid}, 32'd0);
        expectNext = 1'b0;
      end else begin
        monE = expQ.pop_front();
        checkOutput("dout", dout, monE.data);
        checkOutput("dout_addr", {28'd0, dout_addr}, {28'd0, monE.addr});
        checkOutput("dout_last", {31'd0, dout_last}, {31'd0, monE.last});
        checkOutput("dout_blk_op", 32'(dout_blk_op), 32'(monE.op));
        checkOutput("dout_ctx", {31'd0, dout_ctx}, {31'd0, monE.ctx});
        if (monE.last) begin
          fullModel[{monE.ctx, monE.seq}] = 1'b0;
          rdSeqModel[monE.ctx]            = ~rdSeqModel[monE.ctx];
        end
        expectNext = !monE.last;
      end
    end else if (expectNext) begin
      checkOutput("stall", {31'd0, dout_valid}, 32'd1);
      expectNext = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic acc;
    int   n;
    nChecks         = 0;
    nFail           = 0;
    expectNext      = 1'b0;
    RESET_N         = 1'b0;
    wr_en           = 1'b0;
    din             = '0;
    wr_addr         = '0;
    blk_op          = '0;
    input_ctx       = 1'b0;
    input_seq       = 1'b0;
    set_input_ready = 1'b0;
    rd_start        = 1'b0;
    rd_ctx          = 1'b0;
    modelReset();

    // Reset values
    repeat (2) @(negedge CLK);
    checkOutput("rst_ready", {28'd0, ready}, 32'hF);
    checkOutput("rst_avail", {30'd0, blk_avail}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_valid", {31'd0, dout_valid}, 32'd0);
    checkOutput("rst_last", {31'd0, dout_last}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_dout", dout, 32'd0);
    checkOutput("rst_addr", {28'd0, dout_addr}, 32'd0);
    checkOutput("rst_op", 32'(dout_blk_op), 32'd0);
    RESET_N = 1'b1;

    $display("[TB] basic block ctx0 seq0");
    writeBlock(1'b0, 1'b0, 32'h1000, 3'd2);
    checkOutput("basic_ready", {28'd0, ready}, 32'hE);
    checkOutput("basic_avail", {30'd0, blk_avail}, 32'h1);
    checkFlags("basic");
    startRead(1'b0);
    waitIdle();
    checkOutput("basic_ready_back", {28'd0, ready}, 32'hF);
    checkFlags("basic_done");

    $display("[TB] sequence order ctx1");
    writeBlock(1'b1, 1'b1, 32'h2000, 3'd1);
    checkOutput("seq_avail_seq1only", {30'd0, blk_avail}, 32'h0);
    checkFlags("seq1");
    writeBlock(1'b1, 1'b0, 32'h3000, 3'd3);
    checkOutput("seq_avail_both", {30'd0, blk_avail}, 32'h2);
    startRead(1'b1);
    waitIdle();
    checkFlags("seq_first");
    startRead(1'b1);
    waitIdle();
    checkFlags("seq_second");

    $display("[TB] overlap and back-to-back");
    writeBlock(1'b0, rdSeqModel[0], 32'h5000, 3'd4);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, rdSeqModel[1], 4'(i), 32'h5100 + 32'(i), i == 15, 3'd6);
      rd_start = 1'b1;
      if (i == 0) begin
        rd_ctx = 1'b0;
        acc    = modelRead(1'b0);
      end else begin
        rd_ctx = 1'b1;
      end
    end
    idleInputs();
    @(negedge CLK);
    checkOutput("ovl_last_busy", {31'd0, busy}, 32'd1);
    checkOutput("ovl_last_flag", {31'd0, dout_last}, 32'd1);
    @(negedge CLK);
    checkOutput("ovl_gap_busy", {31'd0, busy}, 32'd0);
    acc = modelRead(1'b1);
    @(negedge CLK);
    rd_start = 1'b0;
    checkOutput("ovl_b2b_busy", {31'd0, busy}, {31'd0, acc});
    waitIdle();
    checkFlags("ovl");

    $display("[TB] error: read with no block");
    applyReset();
    startRead(1'b0);
    checkFlags("err_rd");

    $display("[TB] error: write to full slot");
    applyReset();
    writeBlock(1'b0, 1'b0, 32'h6000, 3'd6);
    checkFlags("err_wr_pre");
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd3, 32'hDEAD_BEEF, 1'b0, 3'd0);
    idleInputs();
    checkFlags("err_wr");
    startRead(1'b0);
    waitIdle();

    $display("[TB] error: set on full slot");
    applyReset();
    writeBlock(1'b1, 1'b0, 32'h6100, 3'd5);
    checkFlags("err_set_pre");
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b1, 3'd7);
    idleInputs();
    checkFlags("err_set");
    startRead(1'b1);
    waitIdle();

    $display("[TB] reset mid-burst");
    applyReset();
    writeBlock(1'b0, 1'b0, 32'h7000, 3'd1);
    startRead(1'b0);
    waitIdle();
    writeBlock(1'b0, 1'b1, 32'h7100, 3'd2);
    startRead(1'b0);
    n = 0;
    while (!(dout_valid && dout_addr == 4'd7) && n < 30) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("mid_reach_word7", {28'd0, dout_addr}, 32'd7);
    RESET_N = 1'b0;
    #1;
    checkOutput("mid_valid", {31'd0, dout_valid}, 32'd0);
    checkOutput("mid_ready", {28'd0, ready}, 32'hF);
    checkOutput("mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_last", {31'd0, dout_last}, 32'd0);
    checkOutput("mid_addr", {28'd0, dout_addr}, 32'd0);
    modelReset();
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    writeBlock(1'b0, 1'b0, 32'h8000, 3'd3);
    checkOutput("mid_rdseq0", {30'd0, blk_avail}, 32'h1);
    startRead(1'b0);
    waitIdle();
    checkFlags("mid_after");

    $display("[TB] incomplete block");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 4'(i), 32'h9000 + 32'(i), 1'b0, 3'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, 32'd0, 1'b1, 3'd4);
    idleInputs();
    checkOutput("wcnt_ready", {28'd0, ready}, 32'h7);
    checkOutput("wcnt_err", {31'd0, err}, {31'd0, WCNT});

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
